lcd_byte_writer: RTL

- Low-level HD44780 4-bit-bus transmitter sitting directly downstream of lcd_init: lcd_init sequences init commands and text characters; this block puts each byte on LCD_D/LCD_E with correct nibble order, E pulse widths and post-write execution delay.
- One byte per start/done handshake; nibble-only mode covers the 8-bit-to-4-bit wake-up writes (0x3, 0x3, 0x3, 0x2).
- Runs on the 50 MHz board clock.

---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_delay_timer.sv | 27 ++
 rtl/lcd_byte_writer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit-bus drivers (lcd_init, lcd_byte_writer).
// State codes, bus bit positions, command bytes and default 50 MHz timing.
package lcd_pkg;

    typedef logic [2:0] lcd_state_t;

    localparam lcd_state_t IDLE     = 3'd0;
    localparam lcd_state_t HI_SETUP = 3'd1;
    localparam lcd_state_t HI_PULSE = 3'd2;
    localparam lcd_state_t HI_GAP   = 3'd3;
    localparam lcd_state_t LO_SETUP = 3'd4;
    localparam lcd_state_t LO_PULSE = 3'd5;
    localparam lcd_state_t WAIT     = 3'd6;
    localparam lcd_state_t DONE     = 3'd7;

    localparam int unsigned RS_BIT = 4;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    localparam int unsigned DEF_SETUP_CYC      = 4;
    localparam int unsigned DEF_E_HIGH_CYC     = 25;
    localparam int unsigned DEF_NIBBLE_GAP_CYC = 50;
    localparam int unsigned DEF_SHORT_WAIT_CYC = 2500;
    localparam int unsigned DEF_LONG_WAIT_CYC  = 100000;

    // 0x03 is the undocumented alias of return-home and needs the same slow execution time.
    function automatic logic needs_long_wait(input logic rs, input logic nibble_only,
                                             input logic [7:0] data);
        return !rs && !nibble_only &&
               (data == CMD_CLEAR || data == CMD_HOME || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
// Shared by lcd_byte_writer (per-state timing) and lcd_init (power-up delays).
module lcd_delay_timer #(
    parameter int unsigned WIDTH = 17
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// HD44780 4-bit-bus byte transmitter: high nibble then low nibble (or high only),
// each with address setup and E pulse, followed by the command execution wait.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC      = DEF_SETUP_CYC,
    parameter int unsigned E_HIGH_CYC     = DEF_E_HIGH_CYC,
    parameter int unsigned NIBBLE_GAP_CYC = DEF_NIBBLE_GAP_CYC,
    parameter int unsigned SHORT_WAIT_CYC = DEF_SHORT_WAIT_CYC,
    parameter int unsigned LONG_WAIT_CYC  = DEF_LONG_WAIT_CYC
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       rs,
    input  logic       nibble_only,
    output logic       busy,
    output logic       done,
    output logic [4:0] LCD_D,
    output logic       LCD_E
);

    localparam int unsigned MAX_A   = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
    localparam int unsigned MAX_B   = (NIBBLE_GAP_CYC > MAX_A) ? NIBBLE_GAP_CYC : MAX_A;
    localparam int unsigned MAX_C   = (SHORT_WAIT_CYC > MAX_B) ? SHORT_WAIT_CYC : MAX_B;
    localparam int unsigned MAX_CYC = (LONG_WAIT_CYC > MAX_C) ? LONG_WAIT_CYC : MAX_C;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    if (SETUP_CYC == 0 || E_HIGH_CYC == 0 || NIBBLE_GAP_CYC == 0 ||
        SHORT_WAIT_CYC == 0 || LONG_WAIT_CYC == 0) begin : g_bad_param
        $error("lcd_byte_writer: timing parameters must be non-zero");
    end

    lcd_state_t state_q, state_d;
    logic [7:0] data_q;
    logic       rs_q;
    logic       nib_q;
    logic [4:0] lcd_d_q, lcd_d_d;
    logic       lcd_e_q;

    logic          accept;
    logic          tmr_load;
    logic [CW-1:0] tmr_value;
    logic          tmr_zero;
    logic [CW-1:0] wait_m1;

    lcd_delay_timer #(
        .WIDTH(CW)
    ) u_timer (
        .CLK  (CLK),
        .RST_N(RST_N),
        .load (tmr_load),
        .value(tmr_value),
        .zero (tmr_zero)
    );

    assign busy   = (state_q != IDLE) && (state_q != DONE);
    assign done   = (state_q == DONE);
    assign accept = start && !busy;

    assign wait_m1 = needs_long_wait(rs_q, nib_q, data_q) ? CW'(LONG_WAIT_CYC - 1)
                                                           : CW'(SHORT_WAIT_CYC - 1);

    // Every timed state is entered with its length minus one loaded, and left on zero.
    always_comb begin
        state_d   = state_q;
        lcd_d_d   = lcd_d_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d   = HI_SETUP;
                    lcd_d_d   = {rs, data[7:4]};
                    tmr_load  = 1'b1;
                    tmr_value = CW'(SETUP_CYC - 1);
                end else begin
                    state_d = IDLE;
                end
            end
            HI_SETUP: begin
                if (tmr_zero) begin
                    state_d   = HI_PULSE;
                    tmr_load  = 1'b1;
                    tmr_value = CW'(E_HIGH_CYC - 1);
                end
            end
            HI_PULSE: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (nib_q) begin
                        state_d   = WAIT;
                        tmr_value = wait_m1;
                    end else begin
                        state_d   = HI_GAP;
                        tmr_value = CW'(NIBBLE_GAP_CYC - 1);
                    end
                end
            end
            HI_GAP: begin
                if (tmr_zero) begin
                    state_d   = LO_SETUP;
                    lcd_d_d   = {rs_q, data_q[3:0]};
                    tmr_load  = 1'b1;
                    tmr_value = CW'(SETUP_CYC - 1);
                end
            end
            LO_SETUP: begin
                if (tmr_zero) begin
                    state_d   = LO_PULSE;
                    tmr_load  = 1'b1;
                    tmr_value = CW'(E_HIGH_CYC - 1);
                end
            end
            LO_PULSE: begin
                if (tmr_zero) begin
                    state_d   = WAIT;
                    tmr_load  = 1'b1;
                    tmr_value = wait_m1;
                end
            end
            WAIT: begin
                if (tmr_zero) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            data_q  <= '0;
            rs_q    <= 1'b0;
            nib_q   <= 1'b0;
            lcd_d_q <= '0;
            lcd_e_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lcd_d_q <= lcd_d_d;
            // E registered from the next state so the strobe is a clean flop output.
            lcd_e_q <= (state_d == HI_PULSE) || (state_d == LO_PULSE);
            if (accept) begin
                data_q <= data;
                rs_q   <= rs;
                nib_q  <= nibble_only;
            end
        end
    end

    assign LCD_D = lcd_d_q;
    assign LCD_E = lcd_e_q;

endmodule
